// File: rtl/ps2_keycode_if.sv
// PS/2 pin pair plus decoded key outputs for ps2_keycode.
// master drives the keyboard pins; slave is the decoder.
interface ps2_keycode_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_event;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  keycode, key_event, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, key_event, frame_err
  );
endinterface

// File: rtl/ps2_keycode.sv
// PS/2 Set 2 receiver and make/break decoder producing a held HID keycode.
// Define PS2_ARROW_KEYS_EN to translate E0-prefixed arrow keys.
module ps2_keycode #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input logic         Clk,
  input logic         Reset_n,
  ps2_keycode_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BIT_W = 3;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t             state, state_nx;
  logic               clk_s1, clk_s2, clk_q, dat_s1, dat_s2;
  logic [BIT_W-1:0]   bit_cnt;
  logic [7:0]         shreg;
  logic               par_bit;
  logic [CNT_W-1:0]   to_cnt;
  logic               brk, ext;

  logic fall_c, timeout_c, frame_ok_c;
  logic start_c, shift_c, par_c, byte_valid_c, err_c;
  logic hit_c;
  logic [7:0] code_c;

  // Set 2 -> HID lookup; returns {hit, code}
  function automatic logic [8:0] xlate(input logic e, input logic [7:0] b);
    logic [8:0] r;
    r = 9'h000;
    if (!e) begin
      case (b)
        8'h4C: r = {1'b1, 8'h33};
        8'h52: r = {1'b1, 8'h34};
        8'h0E: r = {1'b1, 8'h35};
        8'h06: r = {1'b1, 8'h3B};
        8'h5A: r = {1'b1, 8'h28};
        8'h76: r = {1'b1, 8'h29};
        default: r = 9'h000;
      endcase
    end else begin
`ifdef PS2_ARROW_KEYS_EN
      case (b)
        8'h6B: r = {1'b1, 8'h50};
        8'h72: r = {1'b1, 8'h51};
        8'h75: r = {1'b1, 8'h52};
        8'h74: r = {1'b1, 8'h4F};
        default: r = 9'h000;
      endcase
`else
      r = 9'h000;
`endif
    end
    return r;
  endfunction

  // Two-flop synchronizers; lines idle high
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_q  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk;
      clk_s2 <= clk_s1;
      clk_q  <= clk_s2;
      dat_s1 <= bus.ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  assign fall_c     = clk_q & ~clk_s2;
  assign timeout_c  = (state != S_IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign frame_ok_c = (^{shreg, par_bit}) & dat_s2;
  assign {hit_c, code_c} = xlate(ext, shreg);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout_c) begin
      state_nx = S_IDLE;
    end else if (fall_c) begin
      case (state)
        S_IDLE:   if (!dat_s2) state_nx = S_DATA;
        S_DATA:   if (bit_cnt == BIT_W'(7)) state_nx = S_PARITY;
        S_PARITY: state_nx = S_STOP;
        S_STOP:   state_nx = S_IDLE;
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    start_c      = 1'b0;
    shift_c      = 1'b0;
    par_c        = 1'b0;
    byte_valid_c = 1'b0;
    err_c        = 1'b0;
    if (timeout_c) begin
      err_c = 1'b1;
    end else if (fall_c) begin
      case (state)
        S_IDLE:   start_c = ~dat_s2;
        S_DATA:   shift_c = 1'b1;
        S_PARITY: par_c   = 1'b1;
        S_STOP: begin
          byte_valid_c = frame_ok_c;
          err_c        = ~frame_ok_c;
        end
        default: ;
      endcase
    end
  end

  // Frame datapath and idle-clock watchdog
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bit_cnt       <= '0;
      shreg         <= '0;
      par_bit       <= 1'b0;
      to_cnt        <= '0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.frame_err <= err_c;
      if (start_c) bit_cnt <= '0;
      else if (shift_c) bit_cnt <= bit_cnt + BIT_W'(1);
      if (shift_c) shreg <= {dat_s2, shreg[7:1]};
      if (par_c) par_bit <= dat_s2;
      if (fall_c || state == S_IDLE || timeout_c) to_cnt <= '0;
      else to_cnt <= to_cnt + CNT_W'(1);
    end
  end

  // Prefix tracking and held-key update
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      brk           <= 1'b0;
      ext           <= 1'b0;
      bus.keycode   <= 8'h00;
      bus.key_event <= 1'b0;
    end else begin
      bus.key_event <= 1'b0;
      if (err_c) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (byte_valid_c) begin
        if (shreg == 8'hF0) begin
          brk <= 1'b1;
        end else if (shreg == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (hit_c && !brk && code_c != bus.keycode) begin
            bus.keycode   <= code_c;
            bus.key_event <= 1'b1;
          end else if (hit_c && brk && code_c == bus.keycode) begin
            bus.keycode   <= 8'h00;
            bus.key_event <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_keycode.sv
// Scoreboard bench for ps2_keycode: stimulus queues expected pulses, a monitor pops and checks.
module tb_ps2_keycode;
  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  ps2_keycode_if bus();

  ps2_keycode #(.TIMEOUT_CYCLES(5000)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       probe_req = 1'b0;
  logic [7:0] probe_kc = 8'h00;
  string      probe_name = "";

  // Monitor: every output pulse must match the head of the queue; probes check idle state
  always @(negedge Clk) begin
    exp_t e;
    if (bus.key_event || bus.frame_err) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: key_event=%0b frame_err=%0b keycode=%02h, nothing expected",
                 bus.key_event, bus.frame_err, bus.keycode);
      end else begin
        e = sb.pop_front();
        if (e.is_err) begin
          if (!bus.frame_err || bus.key_event) begin
            n_bad++;
            $display("FAIL err_pulse: key_event=%0b frame_err=%0b, required frame_err only",
                     bus.key_event, bus.frame_err);
          end
        end else if (!bus.key_event || bus.frame_err || bus.keycode != e.code) begin
          n_bad++;
          $display("FAIL key_pulse: key_event=%0b frame_err=%0b keycode=%02h, required event with %02h",
                   bus.key_event, bus.frame_err, bus.keycode, e.code);
        end
      end
    end
    if (probe_req) begin
      n_cmp++;
      if (bus.keycode != probe_kc || bus.key_event || bus.frame_err) begin
        n_bad++;
        $display("FAIL %s: keycode=%02h key_event=%0b frame_err=%0b, required %02h/0/0",
                 probe_name, bus.keycode, bus.key_event, bus.frame_err, probe_kc);
      end
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL %s_pending: %0d expected pulses never seen, required 0", probe_name, sb.size());
        sb.delete();
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge Clk);
  endtask

  task automatic expect_key(input logic [7:0] c);
    exp_t e;
    e.is_err = 1'b0;
    e.code   = c;
    sb.push_back(e);
  endtask

  task automatic expect_err();
    exp_t e;
    e.is_err = 1'b1;
    e.code   = 8'h00;
    sb.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    bus.ps2_data = b;
    wait_clks(10);
    bus.ps2_clk = 1'b0;
    wait_clks(20);
    bus.ps2_clk = 1'b1;
    wait_clks(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic p;
    p = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(1'b1);
    bus.ps2_data = 1'b1;
    wait_clks(50);
  endtask

  task automatic probe(input logic [7:0] kc, input string nm, input bit now);
    if (!now) begin
      @(posedge Clk);
      #1;
    end
    probe_kc   = kc;
    probe_name = nm;
    probe_req  = 1'b1;
    @(negedge Clk);
    #1;
    probe_req = 1'b0;
  endtask

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_clks(5);
    probe(8'h00, "in_reset", 1'b1);
    Reset_n = 1'b1;
    wait_clks(5);
    probe(8'h00, "after_reset", 1'b0);

    // single make, then release
    expect_key(8'h33); send_frame(8'h4C, 0);
    probe(8'h33, "make_4c", 0);
    expect_key(8'h00); send_frame(8'hF0, 0); send_frame(8'h4C, 0);
    probe(8'h00, "break_4c", 0);

    // typematic repeat fires no event
    expect_key(8'h34); send_frame(8'h52, 0);
    send_frame(8'h52, 0);
    probe(8'h34, "repeat_52", 0);
    expect_key(8'h00); send_frame(8'hF0, 0); send_frame(8'h52, 0);
    probe(8'h00, "break_52", 0);

    // new make replaces held key; break of the old key is ignored
    expect_key(8'h35); send_frame(8'h0E, 0);
    expect_key(8'h3B); send_frame(8'h06, 0);
    send_frame(8'hF0, 0); send_frame(8'h0E, 0);
    probe(8'h3B, "stale_break", 0);
    expect_key(8'h00); send_frame(8'hF0, 0); send_frame(8'h06, 0);
    probe(8'h00, "break_06", 0);

    // bad parity, then recovery
    expect_err(); send_frame(8'h4C, 1);
    probe(8'h00, "bad_parity", 0);
    expect_key(8'h33); send_frame(8'h4C, 0);
    expect_key(8'h00); send_frame(8'hF0, 0); send_frame(8'h4C, 0);
    probe(8'h00, "after_parity", 0);

    // glitch with data high in idle is ignored
    bus.ps2_data = 1'b1;
    bus.ps2_clk = 1'b0; wait_clks(20); bus.ps2_clk = 1'b1; wait_clks(50);
    probe(8'h00, "idle_glitch", 0);

    // mid-frame timeout
    expect_err();
    for (int i = 0; i < 5; i++) send_bit(i == 0 ? 1'b0 : 1'b1);
    bus.ps2_data = 1'b1;
    wait_clks(5100);
    probe(8'h00, "timeout", 0);
    expect_key(8'h3B); send_frame(8'h06, 0);
    probe(8'h3B, "after_timeout", 0);
    expect_key(8'h00); send_frame(8'hF0, 0); send_frame(8'h06, 0);

    // remaining table entries and an unmapped code
    expect_key(8'h28); send_frame(8'h5A, 0);
    expect_key(8'h29); send_frame(8'h76, 0);
    send_frame(8'h1C, 0);
    probe(8'h29, "unmapped", 0);
    expect_key(8'h00); send_frame(8'hF0, 0); send_frame(8'h76, 0);

    // extended keys
`ifdef PS2_ARROW_KEYS_EN
    expect_key(8'h52); send_frame(8'hE0, 0); send_frame(8'h75, 0);
    probe(8'h52, "arrow_make", 0);
    expect_key(8'h00); send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
    probe(8'h00, "arrow_break", 0);
`else
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    send_frame(8'hE0, 0); send_frame(8'h12, 0);
    probe(8'h00, "ext_ignored", 0);
    expect_key(8'h3B); send_frame(8'h06, 0);
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h06, 0);
    probe(8'h3B, "ext_break_ignored", 0);
`endif

    // async reset mid-frame while a key is held
    expect_key(8'h33); send_frame(8'h4C, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    probe(8'h00, "async_reset", 1);
    wait_clks(3);
    Reset_n = 1'b1;
    bus.ps2_data = 1'b1;
    wait_clks(20);
    expect_key(8'h35); send_frame(8'h0E, 0);
    probe(8'h35, "after_reset_frame", 0);

    wait_clks(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
